// File: rtl/alzette_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alzette_seq_ctrl
// Brief    : Sequences one complete Alzette ARX-box (x,y,c) -> (x',y') over a
//            shared xalu_ise datapath.
//            - Issues the eight ISE ops in order: four add-rotates, each
//              followed by an xor-rotate.
//            - Folds x ^= c into the same edge that writes each y result.
//            - Reports a timeout abort through rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module alzette_seq_ctrl #(
    // Variant mask of the attached datapath; V2 (bit 2) and V3 (bit 3) needed
    parameter logic [4:0] ISE_V   = 5'b11110,
    // Maximum cycles to wait for dp_oval on any one step (1..255)
    parameter int         TIMEOUT = 16
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    // command side
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic [31:0] cmd_x,
    input  logic [31:0] cmd_y,
    input  logic [31:0] cmd_c,
    // response side
    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_x,
    output logic [31:0] rsp_y,
    output logic        rsp_err,
    // datapath side
    output logic        dp_val,
    output logic [5:0]  dp_fn,
    output logic [6:0]  dp_imm,
    output logic [31:0] dp_in1,
    output logic [31:0] dp_in2,
    input  logic        dp_oval,
    input  logic [31:0] dp_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Timer value on which a still-silent datapath causes an abort
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] c_LAST_STEP  = 3'd7;
    // A datapath without both V2 and V3 cannot run the box. Such a command
    // is answered immediately with rsp_err=1 and nothing is issued.
    localparam logic       c_VARIANT_OK = ISE_V[2] & ISE_V[3];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_step;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [31:0] r_c;
    logic [7:0]  r_timer;
    logic        r_err;

    logic [1:0]  w_slot;
    logic [6:0]  w_funct7;
    logic        w_dest_y;
    logic        w_issue;
    logic        w_accept;
    logic        w_step_ok;
    logic        w_timeout;
    logic        w_release;

    // Step table. Even steps update x with an add-rotate (rs1=x, rs2=y).
    // Odd steps update y with an xor-rotate (rs1=y, rs2=x).
    always_comb begin
        w_slot   = 2'd3;
        w_funct7 = 7'b0000000;
        case (r_step)
            3'd0: w_funct7 = 7'b0100000;   // x += ror(y,31)
            3'd1: w_funct7 = 7'b0101000;   // y ^= ror(x,24)
            3'd2: w_funct7 = 7'b0100001;   // x += ror(y,17)
            3'd3: w_funct7 = 7'b0100111;   // y ^= ror(x,17)
            3'd4: begin                    // x += y (V2 add, imm 0)
                w_slot   = 2'd1;
                w_funct7 = 7'b0000000;
            end
            3'd5: w_funct7 = 7'b0100110;   // y ^= ror(x,31)
            3'd6: w_funct7 = 7'b0100010;   // x += ror(y,24)
            3'd7: w_funct7 = 7'b0101001;   // y ^= ror(x,16)
            default: begin
                w_slot   = 2'd3;
                w_funct7 = 7'b0000000;
            end
        endcase
    end

    assign w_dest_y  = r_step[0];
    assign w_issue   = (r_state == S_ISSUE);
    assign w_accept  = (r_state == S_IDLE) && cmd_val;
    // dp_oval only counts while a request is actually outstanding
    assign w_step_ok = w_issue && dp_oval;
    assign w_timeout = w_issue && !dp_oval && (r_timer == c_TIMER_LAST);
    assign w_release = (r_state == S_DONE) && rsp_rdy;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_val) begin
                    w_state_nxt = c_VARIANT_OK ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_step_ok && (r_step == c_LAST_STEP)) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath request. The bus is zeroed when idle and is held steady
    // while waiting, because it depends only on registered state.
    always_comb begin
        dp_val = 1'b0;
        dp_fn  = 6'd0;
        dp_imm = 7'd0;
        dp_in1 = 32'd0;
        dp_in2 = 32'd0;
        if (w_issue) begin
            dp_val = 1'b1;
            dp_fn  = {4'b0000, w_slot};
            dp_imm = w_funct7;
            dp_in1 = w_dest_y ? r_y : r_x;
            dp_in2 = w_dest_y ? r_x : r_y;
        end
    end

    assign cmd_rdy = (r_state == S_IDLE);
    assign rsp_val = (r_state == S_DONE);
    assign rsp_x   = r_x;
    assign rsp_y   = r_y;
    assign rsp_err = r_err;

    // State register
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Working registers: operands, step counter, wait timer and error flag
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            r_x     <= 32'd0;
            r_y     <= 32'd0;
            r_c     <= 32'd0;
            r_step  <= 3'd0;
            r_timer <= 8'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_c     <= cmd_c;
            r_step  <= 3'd0;
            r_timer <= 8'd0;
            r_err   <= !c_VARIANT_OK;
        end else if (w_step_ok) begin
            if (w_dest_y) begin
                // y update and the round-constant fold share one edge
                r_y <= dp_out;
                r_x <= r_x ^ r_c;
            end else begin
                r_x <= dp_out;
            end
            r_step  <= r_step + 3'd1;
            r_timer <= 8'd0;
        end else if (w_issue) begin
            if (w_timeout) begin
                r_err <= 1'b1;
            end else begin
                r_timer <= r_timer + 8'd1;
            end
        end else if (w_release) begin
            r_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
